// File: rtl/ff_pipe.sv
// Elastic register pipeline: DEPTH stages of N bits with valid/ready on both ends and bubble collapsing.
// Optional occupancy counter on the count port when FF_PIPE_COUNT_EN is defined; otherwise count is 0.
module ff_pipe #(
    parameter int N     = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic [N-1:0]  i,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  o,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    generate
        if (DEPTH < 1) begin : g_badDepth
            $error("ff_pipe: DEPTH must be at least 1");
        end
    endgenerate

    logic [N-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_ready;

    // A stage can advance unless it and every stage after it are full and the consumer is stalled.
    always_comb begin : ready_chain
        logic w_fullTail;
        w_fullTail = 1'b1;
        w_ready    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_fullTail = w_fullTail & r_valid[k];
            w_ready[k] = !w_fullTail || out_ready;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (en) begin
            if (w_ready[0]) begin
                r_data[0]  <= i;
                r_valid[0] <= in_valid;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_ready[k]) begin
                    r_data[k]  <= r_data[k-1];
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end
    end

    assign in_ready  = en && !flush && !rst && w_ready[0];
    assign out_valid = en && !flush && r_valid[DEPTH-1];
    assign o         = r_data[DEPTH-1];

`ifdef FF_PIPE_COUNT_EN
    logic          w_inXfer;
    logic          w_outXfer;
    logic [CW-1:0] r_count;

    assign w_inXfer  = in_valid && in_ready;
    assign w_outXfer = out_valid && out_ready;

    // Tracks the number of set valid bits; flush empties the pipe so it clears too.
    always_ff @(posedge CLK) begin
        if (rst || flush) begin
            r_count <= '0;
        end else if (en) begin
            case ({w_inXfer, w_outXfer})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
`else
    assign count = '0;
`endif

endmodule

// File: doc/ff_pipe.md
# ff_pipe

Parametrised elastic register pipeline for the sha256crypt datapath: a chain of DEPTH registers, each N bits wide, with a per-stage valid bit and valid/ready handshake on both ends. It generalises the single enable/reset flip-flop word used inside the SHA-256 core. Use it to retime wide buses between cores, the arbiter and the output unit without losing words under back-pressure. Bubbles collapse: an empty stage accepts data even when the stage downstream is stalled.

## Interface
- N, default 32: data width in bits, ≥1.
- DEPTH, default 2: number of register stages, ≥1. DEPTH=0 is illegal and must fail elaboration.
- Reset rst, synchronous, active-high; clock CLK.
- CLK, input, 1: clock; all state changes on the posedge.
- rst, input, 1: synchronous active-high reset.
- en, input, 1: global enable. When 0, the pipeline is frozen.
- flush, input, 1: synchronous clear of all valid bits.
- i, input, N: input data.
- in_valid, input, 1: i holds a word to transfer.
- in_ready, output, 1: the pipeline accepts the word this cycle.
- o, output, N: data in the last stage.
- out_valid, output, 1: o holds a word to transfer.
- out_ready, input, 1: the consumer accepts o this cycle.
- count, output, CW=$clog2(DEPTH+1): number of occupied stages.

## Operation
- State per stage k (0 = input side, DEPTH-1 = output side): data d[k] (N bits) and valid v[k].
- Ready chain, combinational:
  - r[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - r[k] = !v[k] || r[k+1].
- in_ready = en && !flush && !rst && r[0].
- out_valid = en && !flush && v[DEPTH-1].
- o = d[DEPTH-1], whatever the valid state.
- Stage update at a posedge, with en=1, flush=0, rst=0:
  - Stage 0 loads i when r[0]; then v[0] <= in_valid.
  - Stage k>0 loads d[k-1] when r[k]; then v[k] <= v[k-1].
  - A stage with r[k]=0 holds its data and valid bit.
- Data registers load on r[k] even when the incoming valid is 0. Their contents are don't-care while the valid bit is 0.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Priority is rst > flush > en.
  - rst: every v[k] <= 0, every d[k] <= 0, count <= 0.
  - flush (rst=0): every v[k] <= 0; data registers hold; no transfer on either side.
  - en=0 (rst=0, flush=0): all registers hold; in_ready=0 and out_valid=0, so no transfer occurs.
- Words leave in the order they entered. None is duplicated or dropped, except on flush or rst.

## Timing
- Output reset values (cycle after rst): o=0, out_valid=0, count=0. in_ready=0 during the rst cycle and 1 in the following cycle if en=1 and flush=0.
- Latency: a word accepted at edge t appears on o with out_valid=1 after edge t+DEPTH-1, i.e. DEPTH cycles from acceptance to first visibility, when there are no stalls.
- Throughput: 1 word/cycle sustained with out_ready held at 1.
- Full pipeline (all v=1) with out_ready=0: in_ready=0.
- Full pipeline with out_ready=1: in_ready=1, and accept and emit happen in the same cycle. This is a combinational path from out_ready to in_ready by design.
- After an out_ready stall, bubbles fill first. The pipeline holds exactly DEPTH words before in_ready drops.
- flush asserted in the same cycle as in_valid: the word is not accepted (in_ready=0), and the pipeline is empty afterwards.
- rst mid-stream: all in-flight words are lost; out_valid is 0 in the next cycle.
- count changes per cycle by +1 (accept only), -1 (emit only) or 0 (both or neither). It saturates structurally at DEPTH and never wraps.

## Configuration
- FF_PIPE_COUNT_EN defined:
  - count is a registered up/down counter updated from the transfer strobes.
  - It must equal popcount(v) after every edge.
- FF_PIPE_COUNT_EN undefined:
  - count is tied to 0 and no counter logic is synthesised.
  - All other behaviour is identical.

## Test plan
- Reset, then DEPTH=2, N=32, push 0x00000001..0x00000008 with out_ready=1 -> same sequence on o; first out_valid 2 cycles after the first accept; one word/cycle; count steady at 2.
- DEPTH=3, push 0xA5A5A5A5, 0x5A5A5A5A, 0xDEADBEEF, 0x12345678 with out_ready=0 -> in_ready drops after 3 accepts, count=3. Then raise out_ready -> words emerge in order, and 0x12345678 is accepted in the same cycle as the first emit.
- Random in_valid/out_ready (50%), 10000 words -> output stream equals input stream exactly; with FF_PIPE_COUNT_EN defined, count equals the scoreboard occupancy every cycle.
- Pipeline holding 2 words, pulse flush with in_valid=1, i=0xCAFEF00D -> in_ready=0 and out_valid=0 in that cycle; afterwards out_valid=0 and count=0, and 0xCAFEF00D never appears.
- en=0 for 5 cycles mid-stream with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, o unchanged; resumes with no loss or duplication.
- rst while full -> next cycle o=0, out_valid=0, count=0, in_ready=1 (en=1).
